// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity encodings, FSM states,
// frame-length and parity helpers.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic int frame_bits(input int data_w, input int stop_bits, input logic par_en);
        return data_w + stop_bits + (par_en ? 32'sd2 : 32'sd1);
    endfunction

    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Data is zero-extended to 9 bits; extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock first-word-fall-through FIFO feeding the UART serialiser.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push_s, do_pop_s;

    assign full_o    = (cnt_q == CW'(DEPTH));
    assign empty_o   = (cnt_q == CW'(0));
    assign do_pop_s  = pop_i & ~empty_o;
    // A push while full only lands when the same cycle frees a slot.
    assign do_push_s = push_i & (~full_o | do_pop_s);
    assign dout_o    = mem_q[rd_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push_s) begin
            wr_d = wr_q + AW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (do_pop_s) begin
            rd_d = rd_q + AW'(1);
        end else begin
            rd_d = rd_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_W data bits LSB-first, optional parity, 1-2 stop bits.
// Optional input FIFO enabled by defining UART_TX_FIFO_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic [1:0]        par_mode_i,
    output logic              tx_busy_o,
    output logic              rs232_tx_o
);

    localparam int                BAUD_W    = $clog2(CLK_DIV);
    localparam int                IDX_W     = $clog2(DATA_W + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    if (CLK_DIV < 2 || CLK_DIV > 65535 || DATA_W < 5 || DATA_W > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
        $error("uart_tx_frame: illegal parameter value");
    end

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              stop_q, stop_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              tx_q, tx_d;
    logic              busy_q;
    logic              ready_q, ready_d_s;
    logic              bit_end_s, final_s, start_s;
    logic [DATA_W-1:0] word_data_s;
    logic [1:0]        word_mode_s;

    assign bit_end_s = (baud_q == BAUD_LAST);
    assign final_s   = (state_q == ST_STOP) & bit_end_s & (stop_q == STOP_LAST);

`ifdef UART_TX_FIFO_EN
    localparam int FW = DATA_W + 2;

    logic [FW-1:0] fifo_dout_s;
    logic          fifo_full_s, fifo_empty_s, push_s;

    assign push_s     = tx_valid_i & tx_ready_o;
    assign start_s    = ~fifo_empty_s & ((state_q == ST_IDLE) | final_s);
    assign {word_mode_s, word_data_s} = fifo_dout_s;
    assign tx_ready_o = ready_q & ~fifo_full_s;
    assign ready_d_s  = 1'b1;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (start_s),
        .din_i   ({par_mode_i, tx_data_i}),
        .dout_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );
`else
    assign start_s     = tx_valid_i & ready_q;
    assign word_data_s = tx_data_i;
    assign word_mode_s = par_mode_i;
    assign tx_ready_o  = ready_q;
    // Ready is precomputed from next state so the flop is high exactly in
    // IDLE and in the final cycle of the last stop bit.
    assign ready_d_s   = (state_d == ST_IDLE) |
                         ((state_d == ST_STOP) & (baud_d == BAUD_LAST) & (stop_d == STOP_LAST));
`endif

    // Frame sequencing: next state, baud/bit counters and next line level.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        stop_d    = stop_q;
        sh_d      = sh_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        if (state_q == ST_IDLE || bit_end_s) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    tx_d    = sh_q[0];
                    sh_d    = {1'b0, sh_q[DATA_W-1:1]};
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && idx_q == IDX_LAST) begin
                    if (par_en_q) begin
                        state_d = ST_PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d = ST_STOP;
                        stop_d  = 1'b0;
                        tx_d    = 1'b1;
                    end
                end else if (bit_end_s) begin
                    idx_d = idx_q + IDX_W'(1);
                    tx_d  = sh_q[0];
                    sh_d  = {1'b0, sh_q[DATA_W-1:1]};
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                    tx_d    = 1'b1;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s && stop_q == STOP_LAST) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end else if (bit_end_s) begin
                    stop_d = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A new word overrides the IDLE/last-stop outcome and starts at once.
        if (start_s) begin
            state_d   = ST_START;
            baud_d    = '0;
            idx_d     = '0;
            stop_d    = 1'b0;
            sh_d      = word_data_s;
            par_en_d  = par_enabled(word_mode_s);
            par_bit_d = parity_bit(9'(word_data_s), word_mode_s);
            tx_d      = 1'b0;
        end else begin
            sh_d = sh_d;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            idx_q     <= '0;
            stop_q    <= 1'b0;
            sh_q      <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            idx_q     <= idx_d;
            stop_q    <= stop_d;
            sh_q      <= sh_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= (state_d != ST_IDLE);
            ready_q   <= ready_d_s;
        end
    end

    assign rs232_tx_o = tx_q;
    assign tx_busy_o  = busy_q;

endmodule
